uart_tx_fifo: RTL and testbench

- Buffered 8N1 UART transmitter. It is the serial output stage for byte producers such as the score, tile and counter reporters.
- Producers push bytes into an internal FIFO with a single-cycle write strobe, so they no longer poll a busy flag.
- The block drains the FIFO back-to-back onto the tx line at a fixed baud rate.
- It sits directly downstream of any byte source and drives the board's UART TX pin.

---
 rtl/uart_tx_fifo_if.sv | 24 ++
 rtl/uart_tx_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Producer-side bus of the buffered UART transmitter: write strobe, FIFO
// status and the serial line itself.
interface uart_tx_fifo_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   fifo_count;
  logic              overflow;
  logic              tx;
  logic              busy;

  modport master (
    output wr_en, wr_data,
    input  full, empty, fifo_count, overflow, tx, busy
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, fifo_count, overflow, tx, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO written with a single-cycle
// strobe, drained back-to-back onto a registered tx line.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_W        = ADDR_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e              state_q,    state_d;
  logic [BAUD_W-1:0]   baud_q,     baud_d;
  logic [2:0]          bit_idx_q,  bit_idx_d;
  logic [7:0]          shift_q,    shift_d;
  logic                tx_q,       tx_d;
  logic                busy_q,     busy_d;
  logic [ADDR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0]    count_q,    count_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [7:0]          mem_d [FIFO_DEPTH];

  logic full_w;
  logic push_w;
  logic pop_w;

  assign full_w = (count_q == DEPTH_CNT);
  assign push_w = bus.wr_en && !full_w;

  // Write path: tail pointer, storage and sticky overflow flag.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    if (push_w) begin
      mem_d[wr_ptr_q] = bus.wr_data;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (bus.wr_en && full_w) begin
      overflow_d = 1'b1;
    end
  end

  // Frame FSM: pops the head in IDLE and steps START/DATA/STOP per baud period.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rd_ptr_d  = rd_ptr_q;
    pop_w     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop_w    = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          baud_d   = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Occupancy and line outputs; tx follows the registered state one cycle later.
  always_comb begin
    count_d = count_q;
    if (push_w && !pop_w) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_w && pop_w) begin
      count_d = count_q - CNT_W'(1);
    end
    busy_d = (state_d != S_IDLE);
    unique case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[bit_idx_q];
      default: tx_d = 1'b1;
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.full       = full_w;
  assign bus.empty      = (count_q == '0);
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line monitor decodes frames and
// compares them against a queue of bytes the bench has written.
module tb_uart_tx_fifo;

  localparam int unsigned CPB = 10;

  logic clk;
  logic rst;

  uart_tx_fifo_if #(.ADDR_W(4)) bus ();

  uart_tx_fifo #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (100_000),
    .FIFO_DEPTH(16),
    .ADDR_W    (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [7:0]  exp_q[$];
  longint      start_q[$];
  longint      cyc = 0;

  bit          mon_active = 1'b0;
  int          mon_cnt = 0;
  logic        tx_prev = 1'b1;
  logic [7:0]  mon_byte;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: samples each bit mid-period on the falling clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      mon_active = 1'b0;
      mon_cnt    = 0;
      tx_prev    = 1'b1;
    end else if (!mon_active) begin
      if (tx_prev === 1'b1 && bus.tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        start_q.push_back(cyc);
      end
      tx_prev = bus.tx;
    end else begin
      mon_cnt++;
      if (mon_cnt == 5) begin
        tests++;
        if (bus.tx !== 1'b0) begin
          fails++;
          $display("FAIL start_bit: tx=%b required 0", bus.tx);
        end
      end else if (mon_cnt >= 15 && mon_cnt <= 85 && ((mon_cnt - 15) % 10) == 0) begin
        mon_byte[(mon_cnt - 15) / 10] = bus.tx;
      end else if (mon_cnt == 95) begin
        tests++;
        if (bus.tx !== 1'b1) begin
          fails++;
          $display("FAIL stop_bit: tx=%b required 1", bus.tx);
        end
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL frame_unexpected: got 0x%02h, none expected", mon_byte);
        end else begin
          if (mon_byte !== exp_q[0]) begin
            fails++;
            $display("FAIL frame_data: got 0x%02h required 0x%02h", mon_byte, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        mon_active = 1'b0;
        tx_prev    = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    bus.wr_en = 1'b0;
    repeat (n) tick();
    exp_q.delete();
    start_q.delete();
    rst = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit accepted);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (accepted) exp_q.push_back(b);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < max_cycles) begin
      tick();
      n++;
    end
    tests++;
    if (n >= max_cycles) begin
      fails++;
      $display("FAIL %s_drain: %0d bytes still pending after %0d cycles, required 0",
               name, exp_q.size(), max_cycles);
    end
  endtask

  task automatic test_reset();
    do_reset(5);
    tick();
    tests++; if (bus.tx !== 1'b1)         begin fails++; $display("FAIL reset_tx: %b required 1", bus.tx); end
    tests++; if (bus.busy !== 1'b0)       begin fails++; $display("FAIL reset_busy: %b required 0", bus.busy); end
    tests++; if (bus.empty !== 1'b1)      begin fails++; $display("FAIL reset_empty: %b required 1", bus.empty); end
    tests++; if (bus.full !== 1'b0)       begin fails++; $display("FAIL reset_full: %b required 0", bus.full); end
    tests++; if (bus.fifo_count !== 5'd0) begin fails++; $display("FAIL reset_count: %0d required 0", bus.fifo_count); end
    tests++; if (bus.overflow !== 1'b0)   begin fails++; $display("FAIL reset_overflow: %b required 0", bus.overflow); end
  endtask

  task automatic test_single();
    logic [9:0] line;
    logic       tx_s [1:110];
    logic       busy_s [1:110];
    int         bad;
    int         busy_n;
    logic       exp_tx;
    do_reset(2);
    line = {1'b1, 8'hA5, 1'b0};
    write_byte(8'hA5, 1'b1);
    tests++;
    if (bus.fifo_count !== 5'd1) begin fails++; $display("FAIL single_count_after_write: %0d required 1", bus.fifo_count); end
    for (int c = 1; c <= 110; c++) begin
      tick();
      tx_s[c]   = bus.tx;
      busy_s[c] = bus.busy;
    end
    for (int b = -1; b <= 10; b++) begin
      bad = 0;
      for (int c = 1; c <= 110; c++) begin
        if (b == -1 && c < 2) exp_tx = 1'b1;
        else if (b == 10 && c >= 102) exp_tx = 1'b1;
        else if (b >= 0 && b <= 9 && c >= 2 + b * 10 && c < 12 + b * 10) exp_tx = line[b];
        else continue;
        if (tx_s[c] !== exp_tx) bad++;
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL single_line_slot%0d: %0d wrong cycles, required 0", b, bad);
      end
    end
    busy_n = 0;
    bad    = 0;
    for (int c = 1; c <= 110; c++) begin
      if (busy_s[c] === 1'b1) busy_n++;
      if (busy_s[c] !== ((c >= 1 && c <= 100) ? 1'b1 : 1'b0)) bad++;
    end
    tests++;
    if (busy_n != 100 || bad != 0) begin
      fails++;
      $display("FAIL single_busy: %0d high cycles (%0d misplaced), required 100", busy_n, bad);
    end
    tests++;
    if (bus.fifo_count !== 5'd0) begin fails++; $display("FAIL single_count_end: %0d required 0", bus.fifo_count); end
    wait_drain(50, "single");
  endtask

  task automatic test_burst();
    logic [4:0] exp_cnt [3];
    logic [7:0] data [3];
    int         n;
    do_reset(2);
    exp_cnt[0] = 5'd1; exp_cnt[1] = 5'd1; exp_cnt[2] = 5'd2;
    data[0] = 8'h01; data[1] = 8'h80; data[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      write_byte(data[i], 1'b1);
      tests++;
      if (bus.fifo_count !== exp_cnt[i]) begin
        fails++;
        $display("FAIL burst_count%0d: %0d required %0d", i, bus.fifo_count, exp_cnt[i]);
      end
    end
    n = 0;
    while (start_q.size() < 3 && n < 400) begin tick(); n++; end
    tests++;
    if (start_q.size() < 3) begin
      fails++;
      $display("FAIL burst_frames: %0d starts seen, required 3", start_q.size());
    end else begin
      tests++;
      if (bus.empty !== 1'b1) begin fails++; $display("FAIL burst_empty: %b required 1", bus.empty); end
      for (int i = 1; i < 3; i++) begin
        tests++;
        if (start_q[i] - start_q[i-1] != 64'(10 * CPB + 1)) begin
          fails++;
          $display("FAIL burst_spacing%0d: %0d cycles required %0d", i, start_q[i] - start_q[i-1], 10 * CPB + 1);
        end
      end
    end
    wait_drain(400, "burst");
  endtask

  task automatic test_overflow();
    do_reset(2);
    for (int i = 0; i <= 16; i++) write_byte(8'(i), 1'b1);
    tests++; if (bus.fifo_count !== 5'd16) begin fails++; $display("FAIL ovf_count_full: %0d required 16", bus.fifo_count); end
    tests++; if (bus.full !== 1'b1)        begin fails++; $display("FAIL ovf_full: %b required 1", bus.full); end
    tests++; if (bus.overflow !== 1'b0)    begin fails++; $display("FAIL ovf_no_drop_yet: %b required 0", bus.overflow); end
    write_byte(8'h11, 1'b0);
    tests++; if (bus.overflow !== 1'b1)    begin fails++; $display("FAIL ovf_set: %b required 1", bus.overflow); end
    write_byte(8'h12, 1'b0);
    tests++; if (bus.fifo_count !== 5'd16) begin fails++; $display("FAIL ovf_count_held: %0d required 16", bus.fifo_count); end
    wait_drain(2500, "overflow");
    repeat (20) tick();
    tests++; if (bus.empty !== 1'b1)       begin fails++; $display("FAIL ovf_empty_end: %b required 1", bus.empty); end
    tests++; if (bus.overflow !== 1'b1)    begin fails++; $display("FAIL ovf_sticky: %b required 1", bus.overflow); end
    do_reset(2);
    tests++; if (bus.overflow !== 1'b0)    begin fails++; $display("FAIL ovf_cleared: %b required 0", bus.overflow); end
  endtask

  task automatic test_simul_push_pop();
    do_reset(2);
    for (int i = 0; i < 4; i++) write_byte(8'hC1 + 8'(i), 1'b1);
    tests++; if (bus.fifo_count !== 5'd3) begin fails++; $display("FAIL simul_queued: %0d required 3", bus.fifo_count); end
    repeat (98) tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL simul_idle_gap: busy=%b required 0", bus.busy); end
    write_byte(8'h3C, 1'b1);
    tests++; if (bus.fifo_count !== 5'd3) begin fails++; $display("FAIL simul_count: %0d required 3", bus.fifo_count); end
    tests++; if (bus.busy !== 1'b1)       begin fails++; $display("FAIL simul_popped: busy=%b required 1", bus.busy); end
    wait_drain(600, "simul");
  endtask

  task automatic test_reset_mid_frame();
    int low_n;
    int busy_n;
    do_reset(2);
    write_byte(8'h55, 1'b1);
    repeat (55) tick();
    rst = 1'b0;
    tick();
    exp_q.delete();
    tests++; if (bus.tx !== 1'b1)         begin fails++; $display("FAIL midrst_tx: %b required 1", bus.tx); end
    tests++; if (bus.busy !== 1'b0)       begin fails++; $display("FAIL midrst_busy: %b required 0", bus.busy); end
    tests++; if (bus.empty !== 1'b1)      begin fails++; $display("FAIL midrst_empty: %b required 1", bus.empty); end
    tests++; if (bus.fifo_count !== 5'd0) begin fails++; $display("FAIL midrst_count: %0d required 0", bus.fifo_count); end
    repeat (2) tick();
    rst = 1'b1;
    start_q.delete();
    low_n  = 0;
    busy_n = 0;
    repeat (200) begin
      tick();
      if (bus.tx !== 1'b1) low_n++;
      if (bus.busy !== 1'b0) busy_n++;
    end
    tests++;
    if (low_n != 0 || busy_n != 0 || start_q.size() != 0) begin
      fails++;
      $display("FAIL midrst_no_resume: tx low %0d, busy %0d, starts %0d cycles, required 0",
               low_n, busy_n, start_q.size());
    end
  endtask

  initial begin
    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simul_push_pop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
